// File: rtl/chord_mixer_if.sv
// Bundle between the three note players / control and the chord mixer.
// Handshake: each ready_i is a one-cycle strobe (no back-pressure) qualifying sample_in_i
// that cycle; mix_valid is a one-cycle strobe qualifying a new mix_out, which holds otherwise.
interface chord_mixer_if;
  logic signed [15:0] sample_in_0;
  logic signed [15:0] sample_in_1;
  logic signed [15:0] sample_in_2;
  logic               ready_0;
  logic               ready_1;
  logic               ready_2;
  logic [2:0]         voice_en;
  logic               flush;
  logic               clear_err;
  logic signed [15:0] mix_out;
  logic               mix_valid;
  logic               overlap_err;

  modport slave (
    input  sample_in_0, sample_in_1, sample_in_2,
    input  ready_0, ready_1, ready_2,
    input  voice_en, flush, clear_err,
    output mix_out, mix_valid, overlap_err
  );

  modport master (
    output sample_in_0, sample_in_1, sample_in_2,
    output ready_0, ready_1, ready_2,
    output voice_en, flush, clear_err,
    input  mix_out, mix_valid, overlap_err
  );
endinterface

// File: rtl/chord_mixer.sv
// Collects one sample per enabled voice, then emits a saturated, attenuated sum
// two cycles after the last required strobe.
module chord_mixer #(
  parameter int unsigned ATTEN = 0
) (
  input  logic          clk,
  input  logic          reset,
  chord_mixer_if.slave  bus
);
  localparam logic signed [17:0] MAX_S = 18'sd32767;
  localparam logic signed [17:0] MIN_S = -18'sd32768;

  logic [2:0]         rdy;
  logic [2:0]         captured_q, captured_d, captured_next;
  logic [2:0]         overlap;
  logic               complete;
  logic signed [15:0] smp   [3];
  logic signed [15:0] cap_q [3];
  logic signed [15:0] cap_d [3];
  logic signed [15:0] sum_q [3];
  logic signed [15:0] sum_d [3];
  logic               sum_vld_q, sum_vld_d;
  logic signed [17:0] sum_full, shifted;
  logic signed [15:0] sat;
  logic signed [15:0] mix_out_q, mix_out_d;
  logic               mix_valid_q, mix_valid_d;
  logic               err_q, err_d;

  assign rdy    = {bus.ready_2, bus.ready_1, bus.ready_0};
  assign smp[0] = bus.sample_in_0;
  assign smp[1] = bus.sample_in_1;
  assign smp[2] = bus.sample_in_2;

  // Capture stage: strobes in the completion cycle still belong to this collection.
  always_comb begin
    captured_next = captured_q | rdy;
    complete      = !bus.flush && (captured_next != 3'b000) &&
                    ((captured_next | ~bus.voice_en) == 3'b111);
    overlap       = bus.flush ? 3'b000 : (rdy & captured_q);
    captured_d    = (bus.flush || complete) ? 3'b000 : captured_next;
    sum_vld_d     = complete;
    for (int i = 0; i < 3; i++) begin
      cap_d[i] = (rdy[i] && !bus.flush) ? smp[i] : cap_q[i];
      sum_d[i] = sum_q[i];
      if (complete) sum_d[i] = bus.voice_en[i] ? (rdy[i] ? smp[i] : cap_q[i]) : 16'sd0;
    end
    if (overlap != 3'b000)  err_d = 1'b1;
    else if (bus.clear_err) err_d = 1'b0;
    else                    err_d = err_q;
  end

  // Sum stage: three 16-bit values always fit in 18 signed bits.
  always_comb begin
    sum_full = {{2{sum_q[0][15]}}, sum_q[0]} +
               {{2{sum_q[1][15]}}, sum_q[1]} +
               {{2{sum_q[2][15]}}, sum_q[2]};
    shifted  = sum_full >>> ATTEN;
    if (shifted > MAX_S)      sat = 16'sh7fff;
    else if (shifted < MIN_S) sat = 16'sh8000;
    else                      sat = shifted[15:0];
    mix_valid_d = sum_vld_q && !bus.flush;
    mix_out_d   = mix_valid_d ? sat : mix_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      captured_q  <= 3'b000;
      sum_vld_q   <= 1'b0;
      mix_out_q   <= 16'sd0;
      mix_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cap_q[i] <= 16'sd0;
        sum_q[i] <= 16'sd0;
      end
    end else begin
      captured_q  <= captured_d;
      sum_vld_q   <= sum_vld_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      err_q       <= err_d;
      for (int i = 0; i < 3; i++) begin
        cap_q[i] <= cap_d[i];
        sum_q[i] <= sum_d[i];
      end
    end
  end

  assign bus.mix_out     = mix_out_q;
  assign bus.mix_valid   = mix_valid_q;
  assign bus.overlap_err = err_q;
endmodule

// File: tb/tb_chord_mixer.sv
// Directed bench for chord_mixer: two builds (ATTEN 0 and 2) share one stimulus stream
// and are checked every cycle against a collection-level model plus literal results.
module tb_chord_mixer;
  logic clk;
  logic reset;
  logic signed [15:0] s0, s1, s2;
  logic [2:0] rdy;
  logic [2:0] en;
  logic flush, clear_err;

  chord_mixer_if bus0 ();
  chord_mixer_if bus2 ();

  assign bus0.sample_in_0 = s0;  assign bus2.sample_in_0 = s0;
  assign bus0.sample_in_1 = s1;  assign bus2.sample_in_1 = s1;
  assign bus0.sample_in_2 = s2;  assign bus2.sample_in_2 = s2;
  assign bus0.ready_0 = rdy[0];  assign bus2.ready_0 = rdy[0];
  assign bus0.ready_1 = rdy[1];  assign bus2.ready_1 = rdy[1];
  assign bus0.ready_2 = rdy[2];  assign bus2.ready_2 = rdy[2];
  assign bus0.voice_en = en;     assign bus2.voice_en = en;
  assign bus0.flush = flush;     assign bus2.flush = flush;
  assign bus0.clear_err = clear_err; assign bus2.clear_err = clear_err;

  chord_mixer #(.ATTEN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  chord_mixer #(.ATTEN(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] exp0_q[$];
  logic [15:0] exp2_q[$];
  int          due_q[$];
  bit  m_have[3];
  int  m_val[3];
  bit  m_err;
  int  last0, last2;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_have[i] = 1'b0;
      m_val[i]  = 0;
    end
    m_err = 1'b0;
    last0 = 0;
    last2 = 0;
    exp0_q.delete();
    exp2_q.delete();
    due_q.delete();
  endfunction

  // One collection step with the inputs of cycle n.
  function automatic void model_step(input int n);
    bit any, done, ovl;
    int s;
    int smp[3];
    smp[0] = int'(s0); smp[1] = int'(s1); smp[2] = int'(s2);
    ovl = 1'b0;
    if (flush) begin
      for (int i = 0; i < 3; i++) m_have[i] = 1'b0;
      if (due_q.size() > 0 && due_q[$] == n + 1) begin
        void'(due_q.pop_back());
        void'(exp0_q.pop_back());
        void'(exp2_q.pop_back());
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (rdy[i]) begin
          if (m_have[i]) ovl = 1'b1;
          m_have[i] = 1'b1;
          m_val[i]  = smp[i];
        end
      any = 1'b0;
      done = 1'b1;
      s = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_have[i]) any = 1'b1;
        if (en[i] && !m_have[i]) done = 1'b0;
        if (en[i]) s += m_val[i];
      end
      if (any && done) begin
        exp0_q.push_back(16'(sat16(s)));
        exp2_q.push_back(16'(sat16(s >>> 2)));
        due_q.push_back(n + 2);
        for (int i = 0; i < 3; i++) m_have[i] = 1'b0;
      end
    end
    if (ovl) m_err = 1'b1;
    else if (clear_err) m_err = 1'b0;
  endfunction

  // Compare process: model advances on each rising edge, outputs checked on the falling edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!reset) model_clear();
      else model_step(cyc);
      cyc++;
      @(negedge clk);
      if (!reset) begin
        model_clear();
        chk("rst_valid0", int'(bus0.mix_valid), 0);
        chk("rst_out0", int'(bus0.mix_out), 0);
        chk("rst_err0", int'(bus0.overlap_err), 0);
        chk("rst_valid2", int'(bus2.mix_valid), 0);
        chk("rst_out2", int'(bus2.mix_out), 0);
      end else begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          last0 = int'($signed(exp0_q.pop_front()));
          last2 = int'($signed(exp2_q.pop_front()));
          chk("valid0", int'(bus0.mix_valid), 1);
          chk("valid2", int'(bus2.mix_valid), 1);
        end else begin
          chk("idle0", int'(bus0.mix_valid), 0);
          chk("idle2", int'(bus2.mix_valid), 0);
        end
        chk("out0", int'(bus0.mix_out), last0);
        chk("out2", int'(bus2.mix_out), last2);
        chk("err0", int'(bus0.overlap_err), int'(m_err));
        chk("err2", int'(bus2.overlap_err), int'(m_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] r, input int a, input int b, input int c);
    rdy = r;
    s0 = 16'(a); s1 = 16'(b); s2 = 16'(c);
    tick();
    rdy = 3'b000;
  endtask

  task automatic lit(input string name, input int e0, input int e2);
    chk({name, "_v0"}, int'(bus0.mix_valid), 1);
    chk({name, "_o0"}, int'(bus0.mix_out), e0);
    chk({name, "_v2"}, int'(bus2.mix_valid), 1);
    chk({name, "_o2"}, int'(bus2.mix_out), e2);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0; rdy = 3'b000; s0 = '0; s1 = '0; s2 = '0;
    en = 3'b111; flush = 1'b0; clear_err = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    strobe(3'b111, 1000, 2000, 3000);
    chk("simul_lat1", int'(bus0.mix_valid), 0);
    tick();
    lit("simul", 6000, 1500);
    chk("simul_err", int'(bus0.overlap_err), 0);

    strobe(3'b001, 30000, 0, 0);
    repeat (4) tick();
    strobe(3'b010, 0, 10000, 0);
    repeat (3) tick();
    strobe(3'b100, 0, 0, -1000);
    tick();
    lit("stag_pos", 32767, 9750);
    strobe(3'b111, -20000, -20000, 0);
    tick();
    lit("sat_neg", -32768, -10000);

    en = 3'b101;
    strobe(3'b001, 500, 0, 0);
    strobe(3'b010, 0, 7000, 0);
    strobe(3'b100, 0, 0, -200);
    tick();
    lit("mask", 300, 75);
    en = 3'b111;

    strobe(3'b001, 100, 0, 0);
    strobe(3'b001, 400, 0, 0);
    strobe(3'b110, 0, 1, 1);
    tick();
    lit("ovl", 402, 100);
    chk("ovl_err_set", int'(bus0.overlap_err), 1);
    repeat (3) tick();
    chk("ovl_err_sticky", int'(bus0.overlap_err), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovl_err_clr", int'(bus0.overlap_err), 0);

    strobe(3'b011, 11, 22, 0);
    flush = 1'b1; rdy = 3'b100; s2 = 16'sd99;
    tick();
    flush = 1'b0; rdy = 3'b000;
    strobe(3'b100, 0, 0, 33);
    repeat (3) tick();
    chk("flush_hold", int'(bus0.mix_out), 402);
    strobe(3'b111, 1, 2, 3);
    tick();
    lit("after_flush", 6, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    strobe(3'b111, 10, 20, 30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flight_v", int'(bus0.mix_valid), 0);
    chk("flight_o", int'(bus0.mix_out), 6);

    rdy = 3'b111; s0 = 16'sd100; s1 = 16'sd200; s2 = 16'sd300;
    tick();
    s0 = 16'sd1; s1 = 16'sd1; s2 = 16'sd1;
    tick();
    rdy = 3'b000;
    lit("b2b_a", 600, 150);
    tick();
    lit("b2b_b", 3, 0);

    en = 3'b000;
    strobe(3'b010, 0, 1234, 0);
    tick();
    lit("en_none", 0, 0);
    en = 3'b111;

    strobe(3'b001, 50, 0, 0);
    en = 3'b001;
    tick();
    en = 3'b111;
    tick();
    lit("en_change", 50, 12);

    strobe(3'b111, 7, 7, 7);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstmid_v", int'(bus0.mix_valid), 0);
    chk("rstmid_o", int'(bus0.mix_out), 0);
    tick();
    chk("rstmid_v2", int'(bus0.mix_valid), 0);

    strobe(3'b111, 8000, 8000, 8000);
    tick();
    lit("atten_pos", 24000, 6000);
    strobe(3'b111, -32768, -32768, -32768);
    tick();
    lit("atten_neg", -32768, -24576);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/chord_mixer.md
# chord_mixer

Mixes three per-voice note samples into one 16-bit signed chord sample for the codec conditioner. Sits between the three note players and the codec conditioner. Each voice's sample is captured when that voice strobes ready; strobes need not be simultaneous. Once every enabled voice has delivered, the block emits one saturated, optionally attenuated sum with a single-cycle valid strobe.

## Interface
- ATTEN, 0: arithmetic right-shift applied to the 18-bit sum before saturation; legal range 0–2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- sample_in_0 / sample_in_1 / sample_in_2  in  16 each  signed two's-complement voice samples.
- ready_0 / ready_1 / ready_2  in  1 each  one-cycle strobe: the matching sample_in is valid this cycle.
- voice_en  in  3  bit i enables voice i; a disabled voice contributes 0 and is not waited for.
- flush  in  1  synchronous abort of the collection in progress (e.g. song change).
- clear_err  in  1  synchronous clear of overlap_err.
- mix_out  out  16  signed mixed sample; holds its value between results.
- mix_valid  out  1  one-cycle strobe: mix_out is new this cycle.
- overlap_err  out  1  sticky; a voice delivered twice within one collection.

## Operation
- Capture stage: one 16-bit register and one captured bit per voice. When ready_i=1, store sample_in_i and set captured[i].
- Completion: complete = (captured_next | ~voice_en) == 3'b111, where captured_next includes this cycle's strobes.
  - With voice_en=0, any ready strobe completes with all contributions 0.
  - Completion requires at least one ready strobe in the current or an earlier cycle of the collection.
- On completion:
  - Load the sum stage with the three captured values, masked to 0 where voice_en=0, using voice_en as sampled in the completion cycle.
  - Clear all captured bits on the same edge.
- Overlap: if ready_i=1 while captured[i] is already set:
  - the new value overwrites the stored one;
  - overlap_err is set;
  - the collection continues.
- Sum stage (registered):
  - sign-extend each value to 18 bits and add;
  - shift right arithmetically by ATTEN;
  - saturate to [-32768, 32767].
  - The result registers into mix_out, and mix_valid pulses.
- voice_en changes mid-collection take effect immediately in the completion check. Data already captured for a now-disabled voice is ignored.
- flush=1 clears the captured bits and cancels any result in flight: no mix_valid for it. mix_out keeps its old value. Ready strobes in the flush cycle are dropped.
- overlap_err clears on clear_err=1 or reset. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - mix_out=0, mix_valid=0, overlap_err=0;
  - all captured bits 0;
  - capture and sum registers 0.
- Latency: last required ready in cycle N -> mix_valid=1 in cycle N+2, with mix_out valid in the same cycle.
- Throughput: one result per cycle. A new collection may start in cycle N+1, while result N is still in the sum stage.
- Ready strobes in the completion cycle N belong to collection N; strobes from N+1 onward belong to the next collection.
- Reset asserted mid-pipeline: every output returns to its reset value asynchronously, and no pending result emerges after release.
- mix_valid is never high on two consecutive cycles unless completions occur on consecutive cycles.

## Test plan
- Simultaneous readies: ready_0/1/2 with 1000, 2000, 3000, voice_en=3'b111 -> mix_valid exactly 2 cycles later, mix_out=6000, overlap_err=0.
- Staggered delivery with saturation:
  - 30000, 10000, -1000 on cycles 0, 5, 9 -> mix_valid at cycle 11, mix_out=32767;
  - -20000, -20000, 0 -> mix_out=-32768.
- Masking: voice_en=3'b101, ready_0=500 and ready_2=-200 only -> mix_out=300; a ready_1 strobe carrying 7000 in the same collection does not change mix_out.
- Overlap:
  - ready_0=100, then ready_0=400, then ready_1=1, ready_2=1 -> mix_out=402 and overlap_err=1;
  - overlap_err stays high until clear_err is pulsed, then reads 0.
- Flush and reset:
  - ready_0 and ready_1 delivered, then flush, then only ready_2 -> no mix_valid;
  - a full set after that -> a normal result;
  - reset pulsed low one cycle after completion -> no mix_valid, and mix_out=0.
- ATTEN=2 build: 8000, 8000, 8000 -> mix_out=6000; -32768 ×3 -> mix_out=-24576.
